lane_hit_scorer: RTL and testbench
==================================

Name: lane_hit_scorer

Overview:
Scores player strum/fret pushes against note hit-windows on LANES independent lanes. Each lane runs its own window FSM and grades a hit into one of three accuracy zones. Hits, misses and combo/streak statistics are accumulated in shared counters, with one committed event per cycle through a round-robin serializer. The block sits between the note scroller, which supplies window-open pulses, and the score/LED display path, which consumes the BCD totals and the flash flags.

Parameters:
LANES, 4, number of note lanes (1..8)
WIN_LEN, 2200000, hit-window length in clk cycles (offsets 0..WIN_LEN-1)
EDGE_LEN, 600000, cycles at each window end graded as edge
MID_LEN, 300000, cycles inside each edge graded as mid; 2*(EDGE_LEN+MID_LEN) < WIN_LEN
PTS_EDGE, 3, BCD points for an edge hit (0..9)
PTS_MID, 5, BCD points for a mid hit (0..9)
PTS_CENTER, 7, BCD points for a center hit (0..9)
FLASH_CYCLES, 1000000, flash-flag duration in cycles

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
mode  in  3  game mode; 3'd1 = clear/start, 3'd2 = pause, others = run
note_start  in  LANES  per-lane 1-cycle pulse that opens a hit window
pushed  in  LANES  per-lane 1-cycle debounced push pulse
num_hits  out  16  4-digit BCD accumulated points
num_misses  out  16  4-digit BCD miss count
combo  out  8  binary current streak
max_combo  out  8  binary best streak since clear
good  out  LANES  per-lane hit flash flag
missed  out  LANES  per-lane miss flash flag
overflow  out  1  sticky: an event was dropped

Behaviour:
- Reset: all outputs 0; all lane FSMs IDLE; event buffers empty; round-robin pointer = lane 0.
- Lane FSM states:
  - IDLE: note_start -> OPEN with offset=0.
  - OPEN: offset increments each cycle. A push at offset o -> HIT, and a hit event is generated with points graded on o. If offset reaches WIN_LEN-1 with no push -> IDLE, and a miss event is generated.
  - HIT: pushes are ignored. At offset WIN_LEN-1 -> IDLE, with no event.
- Grading of offset o:
  - o < EDGE_LEN, or o >= WIN_LEN-EDGE_LEN -> PTS_EDGE.
  - Otherwise o < EDGE_LEN+MID_LEN, or o >= WIN_LEN-EDGE_LEN-MID_LEN -> PTS_MID.
  - Otherwise -> PTS_CENTER.
  - A push at offset WIN_LEN-1 is a hit (edge).
- Stray push: a push in IDLE generates a miss event. A push and note_start in the same IDLE cycle count as a stray miss, and the window still opens.
- note_start in OPEN or HIT: ignored.
- Event buffer: one entry per lane (valid, hit/miss, points), written on the edge after the generating cycle. If an event arrives while the lane's entry is still valid, the new event is dropped and overflow is set (sticky until mode==1 or reset).
- Commit serializer:
  - Each cycle, grant the first valid buffer at or after the pointer. Clear that entry and set pointer = granted lane + 1 (mod LANES).
  - Hit commit: num_hits += points (BCD add, saturating at 16'h9999); combo += 1 (saturating at 255); max_combo = max(max_combo, new combo).
  - Miss commit: num_misses += 1 (BCD, saturating at 16'h9999); combo = 0.
  - Latency: push at cycle t -> buffer valid at t+1 -> counters updated at t+2 if granted immediately. Worst case t+1+LANES.
- Flash flags:
  - good[l] / missed[l] assert the cycle after the event is generated (not when committed) and stay high for FLASH_CYCLES cycles.
  - A retrigger restarts the per-lane counter. A hit and a miss flag can overlap on one lane.
- mode==3'd1 (any cycle, including mid-window):
  - Synchronously clears counters, combo, max_combo, overflow, buffers, flash flags and the pointer.
  - Forces all lanes to IDLE. Pending and in-window events are discarded.
  - Pushes and note_start are ignored while mode==3'd1.
- mode==3'd2: lane offsets and flash counters freeze. pushed and note_start are ignored. Commits of already-buffered events continue.

Test Plan:
(bench parameters: LANES=4, WIN_LEN=20, EDGE_LEN=3, MID_LEN=4, FLASH_CYCLES=8; zones: edge 0-2/17-19, mid 3-6/13-16, center 7-12)
1. note_start[0], then pushed[0] at offset 10 -> num_hits=16'h0007, combo=1, max_combo=1, good[0] high for exactly 8 cycles; a second push at offset 12 changes nothing.
2. note_start[1], no push -> after offset 19, num_misses=16'h0001, combo=0, missed[1] high for 8 cycles; push at offset 19 instead -> num_hits += 3.
3. All four lanes opened together, pushed=4'b1111 at offset 0 -> four commits on consecutive cycles in order 0,1,2,3; num_hits=16'h0012, combo=4.
4. Run hits to num_hits=16'h9996, then a center hit -> 16'h9999; a further hit stays at 16'h9999 while combo still increments.
5. combo=3, then stray pushed[2] in IDLE -> num_misses+1, combo=0, max_combo=3; two pushes on one lane in back-to-back cycles while its buffer is held by arbitration -> overflow=1.
6. mode=3'd1 at offset 5 of an open window -> all outputs 0 next cycle, no miss generated when the window would have expired; mode=3'd2 for 10 cycles mid-window -> window closes 10 cycles later than unpaused.

Source files
------------

// File: rtl/lane_hit_scorer_if.sv
// Player-input / score-display bundle for lane_hit_scorer.
// The master side is the game controller, the slave side is the scorer.
interface lane_hit_scorer_if #(
  parameter int unsigned LANES = 4
) ();
  logic [2:0]       mode;
  logic [LANES-1:0] note_start;
  logic [LANES-1:0] pushed;
  logic [15:0]      num_hits;
  logic [15:0]      num_misses;
  logic [7:0]       combo;
  logic [7:0]       max_combo;
  logic [LANES-1:0] good;
  logic [LANES-1:0] missed;
  logic             overflow;

  modport master (
    output mode, note_start, pushed,
    input  num_hits, num_misses, combo, max_combo, good, missed, overflow
  );

  modport slave (
    input  mode, note_start, pushed,
    output num_hits, num_misses, combo, max_combo, good, missed, overflow
  );
endinterface

// File: rtl/lane_hit_scorer.sv
// Per-lane hit-window grading with a round-robin event serializer feeding
// BCD hit/miss totals, combo statistics and per-lane flash flags.
module lane_hit_scorer #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned WIN_LEN      = 2200000,
  parameter int unsigned EDGE_LEN     = 600000,
  parameter int unsigned MID_LEN      = 300000,
  parameter int unsigned PTS_EDGE     = 3,
  parameter int unsigned PTS_MID      = 5,
  parameter int unsigned PTS_CENTER   = 7,
  parameter int unsigned FLASH_CYCLES = 1000000
) (
  input logic             clk,
  input logic             n_rst,
  lane_hit_scorer_if.slave bus
);
  localparam int unsigned OFF_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned FL_W  = $clog2(FLASH_CYCLES + 1);
  localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [OFF_W-1:0] LAST = OFF_W'(WIN_LEN - 1);
  localparam logic [OFF_W-1:0] E_LO = OFF_W'(EDGE_LEN);
  localparam logic [OFF_W-1:0] E_HI = OFF_W'(WIN_LEN - EDGE_LEN);
  localparam logic [OFF_W-1:0] M_LO = OFF_W'(EDGE_LEN + MID_LEN);
  localparam logic [OFF_W-1:0] M_HI = OFF_W'(WIN_LEN - EDGE_LEN - MID_LEN);
  localparam logic [3:0]       P_E  = 4'(PTS_EDGE);
  localparam logic [3:0]       P_M  = 4'(PTS_MID);
  localparam logic [3:0]       P_C  = 4'(PTS_CENTER);
  localparam logic [FL_W-1:0]  FL   = FL_W'(FLASH_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_HIT} lane_state_e;

  function automatic logic [3:0] grade(input logic [OFF_W-1:0] o);
    if (o < E_LO || o >= E_HI)      return P_E;
    else if (o < M_LO || o >= M_HI) return P_M;
    else                            return P_C;
  endfunction

  // 4-digit BCD add of a single digit; any carry out of the top digit saturates.
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [3:0] b);
    logic [15:0] r;
    logic [4:0]  s;
    logic        cy;
    r  = '0;
    cy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + ((i == 0) ? {1'b0, b} : {4'd0, cy});
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        cy          = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        cy          = 1'b0;
      end
    end
    return cy ? 16'h9999 : r;
  endfunction

  logic clear_c, pause_c;
  assign clear_c = (bus.mode == 3'd1);
  assign pause_c = (bus.mode == 3'd2);

  lane_state_e      state_q [LANES];
  lane_state_e      state_d [LANES];
  logic [OFF_W-1:0] off_q   [LANES];
  logic [OFF_W-1:0] off_d   [LANES];
  logic [LANES-1:0] ev_v, ev_hit;
  logic [3:0]       ev_pts  [LANES];

  // Lane window state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int l = 0; l < LANES; l++) begin
        state_q[l] <= S_IDLE;
        off_q[l]   <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        state_q[l] <= state_d[l];
        off_q[l]   <= off_d[l];
      end
    end
  end

  // Lane next-state and event generation
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      state_d[l] = state_q[l];
      off_d[l]   = off_q[l];
      ev_v[l]    = 1'b0;
      ev_hit[l]  = 1'b0;
      ev_pts[l]  = '0;
      if (clear_c) begin
        state_d[l] = S_IDLE;
        off_d[l]   = '0;
      end else if (!pause_c) begin
        case (state_q[l])
          S_IDLE: begin
            ev_v[l] = bus.pushed[l];
            if (bus.note_start[l]) begin
              state_d[l] = S_OPEN;
              off_d[l]   = '0;
            end
          end
          S_OPEN: begin
            off_d[l] = (off_q[l] == LAST) ? '0 : off_q[l] + 1'b1;
            if (bus.pushed[l]) begin
              ev_v[l]    = 1'b1;
              ev_hit[l]  = 1'b1;
              ev_pts[l]  = grade(off_q[l]);
              state_d[l] = (off_q[l] == LAST) ? S_IDLE : S_HIT;
            end else if (off_q[l] == LAST) begin
              ev_v[l]    = 1'b1;
              state_d[l] = S_IDLE;
            end
          end
          S_HIT: begin
            off_d[l] = (off_q[l] == LAST) ? '0 : off_q[l] + 1'b1;
            if (off_q[l] == LAST) state_d[l] = S_IDLE;
          end
          default: state_d[l] = S_IDLE;
        endcase
      end
    end
  end

  logic [LANES-1:0] buf_v_q, buf_hit_q;
  logic [3:0]       buf_pts_q [LANES];
  logic [PTR_W-1:0] ptr_q, gnt, ptr_nxt;
  logic             gnt_v;
  logic [15:0]      hits_q, hits_d, miss_q, miss_d;
  logic [7:0]       combo_q, combo_d, max_q, max_d;
  logic             ovf_q;

  // Round-robin grant: scan from farthest to nearest so the nearest valid wins
  always_comb begin
    int unsigned idx;
    idx   = 0;
    gnt_v = 1'b0;
    gnt   = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % LANES;
      if (buf_v_q[idx]) begin
        gnt_v = 1'b1;
        gnt   = PTR_W'(idx);
      end
    end
    ptr_nxt = (gnt == PTR_W'(LANES - 1)) ? '0 : gnt + 1'b1;
  end

  // Statistics update for the granted event
  always_comb begin
    hits_d  = hits_q;
    miss_d  = miss_q;
    combo_d = combo_q;
    max_d   = max_q;
    if (gnt_v) begin
      if (buf_hit_q[gnt]) begin
        hits_d  = bcd_add(hits_q, buf_pts_q[gnt]);
        combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
        max_d   = (combo_d > max_q) ? combo_d : max_q;
      end else begin
        miss_d  = bcd_add(miss_q, 4'd1);
        combo_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buf_v_q <= '0; buf_hit_q <= '0; ptr_q <= '0; ovf_q <= 1'b0;
      hits_q  <= '0; miss_q    <= '0; combo_q <= '0; max_q <= '0;
      for (int l = 0; l < LANES; l++) buf_pts_q[l] <= '0;
    end else if (clear_c) begin
      buf_v_q <= '0; buf_hit_q <= '0; ptr_q <= '0; ovf_q <= 1'b0;
      hits_q  <= '0; miss_q    <= '0; combo_q <= '0; max_q <= '0;
      for (int l = 0; l < LANES; l++) buf_pts_q[l] <= '0;
    end else begin
      hits_q  <= hits_d;
      miss_q  <= miss_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      if (gnt_v) ptr_q <= ptr_nxt;
      // An event landing on a still-valid entry is dropped, even if that entry is granted now
      for (int l = 0; l < LANES; l++) begin
        if (gnt_v && gnt == PTR_W'(l)) buf_v_q[l] <= 1'b0;
        if (ev_v[l]) begin
          if (buf_v_q[l]) begin
            ovf_q <= 1'b1;
          end else begin
            buf_v_q[l]   <= 1'b1;
            buf_hit_q[l] <= ev_hit[l];
            buf_pts_q[l] <= ev_pts[l];
          end
        end
      end
    end
  end

  logic [FL_W-1:0]  gcnt_q [LANES];
  logic [FL_W-1:0]  gcnt_d [LANES];
  logic [FL_W-1:0]  mcnt_q [LANES];
  logic [FL_W-1:0]  mcnt_d [LANES];
  logic [LANES-1:0] good_q, missed_q;

  // Flash counters restart on every generated event, freeze while paused
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      gcnt_d[l] = gcnt_q[l];
      mcnt_d[l] = mcnt_q[l];
      if (clear_c) begin
        gcnt_d[l] = '0;
        mcnt_d[l] = '0;
      end else if (!pause_c) begin
        if (ev_v[l] && ev_hit[l])  gcnt_d[l] = FL;
        else if (gcnt_q[l] != '0)  gcnt_d[l] = gcnt_q[l] - 1'b1;
        if (ev_v[l] && !ev_hit[l]) mcnt_d[l] = FL;
        else if (mcnt_q[l] != '0)  mcnt_d[l] = mcnt_q[l] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      good_q   <= '0;
      missed_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        gcnt_q[l] <= '0;
        mcnt_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        gcnt_q[l]   <= gcnt_d[l];
        mcnt_q[l]   <= mcnt_d[l];
        good_q[l]   <= (gcnt_d[l] != '0);
        missed_q[l] <= (mcnt_d[l] != '0);
      end
    end
  end

  assign bus.num_hits   = hits_q;
  assign bus.num_misses = miss_q;
  assign bus.combo      = combo_q;
  assign bus.max_combo  = max_q;
  assign bus.good       = good_q;
  assign bus.missed     = missed_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_lane_hit_scorer.sv
// Bench for lane_hit_scorer: directed scenarios plus random traffic, every
// cycle compared against an integer-valued behavioural model of the scorer.
module tb_lane_hit_scorer;
  localparam int LN  = 4;
  localparam int WIN = 20;
  localparam int EDG = 3;
  localparam int MID = 4;
  localparam int FLC = 8;

  logic clk = 1'b0;
  logic n_rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  lane_hit_scorer_if #(.LANES(LN)) bus ();

  lane_hit_scorer #(
    .LANES(LN), .WIN_LEN(WIN), .EDGE_LEN(EDG), .MID_LEN(MID),
    .PTS_EDGE(3), .PTS_MID(5), .PTS_CENTER(7), .FLASH_CYCLES(FLC)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: windows tracked by age since opening, totals kept as plain integers
  bit m_act [LN];
  int m_age [LN];
  bit m_done[LN];
  bit m_pend[LN];
  bit m_phit[LN];
  int m_ppts[LN];
  int m_gfl [LN];
  int m_mfl [LN];
  int m_ptr, m_hits, m_miss, m_combo, m_max;
  bit m_ovf;

  function automatic int pts_of(input int o);
    int d;
    d = (o < WIN - 1 - o) ? o : WIN - 1 - o;
    if (d < EDG)       return 3;
    if (d < EDG + MID) return 5;
    return 7;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    for (int l = 0; l < LN; l++) begin
      m_act[l] = 0; m_age[l] = 0; m_done[l] = 0; m_pend[l] = 0;
      m_phit[l] = 0; m_ppts[l] = 0; m_gfl[l] = 0; m_mfl[l] = 0;
    end
    m_ptr = 0; m_hits = 0; m_miss = 0; m_combo = 0; m_max = 0; m_ovf = 0;
  endtask

  task automatic model_step(input logic [2:0] m, input logic [3:0] ns, input logic [3:0] p);
    bit pp [LN];
    int g;
    bit ev, evh;
    int evp;
    if (m == 3'd1) begin
      model_reset();
      return;
    end
    for (int l = 0; l < LN; l++) pp[l] = m_pend[l];
    g = -1;
    for (int k = 0; k < LN; k++)
      if (g < 0 && m_pend[(m_ptr + k) % LN]) g = (m_ptr + k) % LN;
    if (g >= 0) begin
      m_pend[g] = 0;
      m_ptr = (g + 1) % LN;
      if (m_phit[g]) begin
        m_hits  = (m_hits + m_ppts[g] > 9999) ? 9999 : m_hits + m_ppts[g];
        m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
        if (m_combo > m_max) m_max = m_combo;
      end else begin
        m_miss  = (m_miss >= 9999) ? 9999 : m_miss + 1;
        m_combo = 0;
      end
    end
    if (m == 3'd2) return;
    for (int l = 0; l < LN; l++) begin
      ev = 0; evh = 0; evp = 0;
      if (!m_act[l]) begin
        if (p[l]) ev = 1;
        if (ns[l]) begin m_act[l] = 1; m_age[l] = 0; m_done[l] = 0; end
      end else begin
        if (!m_done[l] && p[l]) begin
          ev = 1; evh = 1; evp = pts_of(m_age[l]); m_done[l] = 1;
        end else if (!m_done[l] && m_age[l] == WIN - 1) begin
          ev = 1;
        end
        if (m_age[l] == WIN - 1) m_act[l] = 0;
        else m_age[l]++;
      end
      if (ev && evh) m_gfl[l] = FLC; else if (m_gfl[l] > 0) m_gfl[l]--;
      if (ev && !evh) m_mfl[l] = FLC; else if (m_mfl[l] > 0) m_mfl[l]--;
      if (ev) begin
        if (pp[l]) m_ovf = 1;
        else begin m_pend[l] = 1; m_phit[l] = evh; m_ppts[l] = evp; end
      end
    end
  endtask

  task automatic expect_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] eg, em;
    for (int l = 0; l < LN; l++) begin
      eg[l] = (m_gfl[l] > 0);
      em[l] = (m_mfl[l] > 0);
    end
    expect_val("num_hits",   bus.num_hits,        to_bcd(m_hits));
    expect_val("num_misses", bus.num_misses,      to_bcd(m_miss));
    expect_val("combo",      16'(bus.combo),      16'(m_combo));
    expect_val("max_combo",  16'(bus.max_combo),  16'(m_max));
    expect_val("good",       16'(bus.good),       16'(eg));
    expect_val("missed",     16'(bus.missed),     16'(em));
    expect_val("overflow",   16'(bus.overflow),   16'(m_ovf));
  endtask

  task automatic tick(input logic [2:0] m, input logic [3:0] ns, input logic [3:0] p);
    bus.mode       = m;
    bus.note_start = ns;
    bus.pushed     = p;
    model_step(m, ns, p);
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    bus.mode       = 3'd0;
    bus.note_start = '0;
    bus.pushed     = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(3'd0, 4'd0, 4'd0);
  endtask

  task automatic center_hit_round();
    tick(3'd0, 4'hF, 4'h0);
    idle(10);
    tick(3'd0, 4'h0, 4'hF);
    idle(9);
  endtask

  initial begin
    logic [3:0] rns, rp;
    logic [2:0] rm;
    int r;
    n_rst = 1'b0;
    bus.mode = 3'd0;
    bus.note_start = '0;
    bus.pushed = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    n_rst = 1'b1;

    // Center hit at offset 10, then an ignored second push
    tick(3'd0, 4'b0001, 4'd0);
    idle(10);
    tick(3'd0, 4'd0, 4'b0001);
    idle(1);
    expect_val("t1_hits", bus.num_hits, 16'h0007);
    expect_val("t1_combo", 16'(bus.combo), 16'd1);
    tick(3'd0, 4'd0, 4'b0001);
    idle(10);
    expect_val("t1_hits_after", bus.num_hits, 16'h0007);

    // Expired window miss, then edge hit at the last offset
    tick(3'd0, 4'b0010, 4'd0);
    idle(20);
    idle(2);
    expect_val("t2_miss", bus.num_misses, 16'h0001);
    expect_val("t2_combo", 16'(bus.combo), 16'd0);
    tick(3'd0, 4'b0010, 4'd0);
    idle(19);
    tick(3'd0, 4'd0, 4'b0010);
    idle(3);
    expect_val("t2_hits", bus.num_hits, 16'h0010);
    idle(10);

    // Four simultaneous edge hits serialized in lane order
    tick(3'd1, 4'd0, 4'd0);
    tick(3'd0, 4'hF, 4'd0);
    tick(3'd0, 4'd0, 4'hF);
    idle(5);
    expect_val("t3_hits", bus.num_hits, 16'h0012);
    expect_val("t3_combo", 16'(bus.combo), 16'd4);
    idle(20);

    // Saturation of the hit total
    tick(3'd1, 4'd0, 4'd0);
    for (int i = 0; i < 357; i++) center_hit_round();
    expect_val("t4_hits9996", bus.num_hits, 16'h9996);
    expect_val("t4_combo255", 16'(bus.combo), 16'd255);
    tick(3'd0, 4'd0, 4'b0100);
    idle(3);
    tick(3'd0, 4'b0001, 4'd0);
    idle(10);
    tick(3'd0, 4'd0, 4'b0001);
    idle(2);
    expect_val("t4_hits9999", bus.num_hits, 16'h9999);
    idle(9);
    tick(3'd0, 4'b0001, 4'd0);
    idle(10);
    tick(3'd0, 4'd0, 4'b0001);
    idle(2);
    expect_val("t4_hits_sat", bus.num_hits, 16'h9999);
    expect_val("t4_combo2", 16'(bus.combo), 16'd2);
    idle(9);

    // Stray miss breaks the streak; repeated events on a held entry overflow
    tick(3'd1, 4'd0, 4'd0);
    tick(3'd0, 4'b0111, 4'd0);
    tick(3'd0, 4'd0, 4'b0111);
    idle(19);
    expect_val("t5_combo3", 16'(bus.combo), 16'd3);
    tick(3'd0, 4'd0, 4'b0100);
    idle(3);
    expect_val("t5_miss", bus.num_misses, 16'h0001);
    expect_val("t5_combo0", 16'(bus.combo), 16'd0);
    expect_val("t5_max", 16'(bus.max_combo), 16'd3);
    tick(3'd0, 4'd0, 4'b1111);
    tick(3'd0, 4'd0, 4'b0100);
    tick(3'd0, 4'd0, 4'b0100);
    idle(6);
    expect_val("t5_ovf", 16'(bus.overflow), 16'd1);

    // Clear mid-window discards everything
    tick(3'd1, 4'd0, 4'd0);
    tick(3'd0, 4'd0, 4'b0010);
    idle(1);
    tick(3'd0, 4'b0001, 4'd0);
    idle(5);
    tick(3'd1, 4'd0, 4'b0001);
    expect_val("t6_clr_miss", bus.num_misses, 16'h0000);
    expect_val("t6_clr_flag", 16'(bus.missed), 16'd0);
    idle(22);
    expect_val("t6_no_miss", bus.num_misses, 16'h0000);

    // Pause stretches the window by the paused cycles
    tick(3'd0, 4'b0001, 4'd0);
    idle(5);
    for (int i = 0; i < 10; i++) tick(3'd2, 4'b0001, 4'b0001);
    idle(15);
    expect_val("t6_pause_open", bus.num_misses, 16'h0000);
    idle(1);
    expect_val("t6_pause_miss", bus.num_misses, 16'h0001);
    idle(20);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom_range(0, 99));
      rm  = (r < 1) ? 3'd1 : (r < 6) ? 3'd2 : 3'(($urandom_range(0, 9) == 0) ? 7 : 0);
      rns = 4'($urandom) & 4'($urandom) & 4'($urandom);
      rp  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      tick(rm, rns, rp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
